// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - 2-way data-cache controller: hit/miss sequencing, write-back, refill and statistics
module dcache_ctrl #(
    parameter int MEM_ACK_TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_read_i,
    input  logic         cpu_write_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    input  logic         sram_hit_i,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o,
    output logic         err_o
);

    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, FILL, REFILL} state_t;
    localparam int CW = $clog2(MEM_ACK_TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [22:0]    tag_q;
    logic [3:0]     idx_q;
    logic [24:0]    vtag_q;
    logic [255:0]   line_q;
    logic           refill_q;
    logic [31:0]    hit_cnt_q, miss_cnt_q;
    logic           err_q;
    logic [CW-1:0]  wait_q;

    logic           req, hit_inc, miss_inc, waiting;
    logic [7:0]     word_lsb;
    logic [255:0]   merged;
    logic           unused_ok;

    assign req       = cpu_read_i | cpu_write_i;
    assign word_lsb  = {cpu_addr_i[4:2], 5'b0};
    assign waiting   = (state_q == WRITEBACK) || (state_q == FILL);
    assign unused_ok = ^cpu_addr_i[1:0];

    always_comb begin
        merged = sram_data_i;
        merged[word_lsb +: 32] = cpu_data_i;
    end

    always_comb begin
        state_d       = state_q;
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b1;
        sram_addr_o   = idx_q;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_stall_o   = 1'b0;
                sram_addr_o   = cpu_addr_i[8:5];
                sram_enable_o = req;
                if (req && sram_hit_i) begin
                    hit_inc = ~refill_q;
                    if (cpu_write_i) begin
                        sram_write_o = 1'b1;
                        sram_data_o  = merged;
                        sram_tag_o   = {2'b11, cpu_addr_i[31:9]};
                    end else begin
                        cpu_data_o = sram_data_i[word_lsb +: 32];
                    end
                end else if (req) begin
                    cpu_stall_o = 1'b1;
                    miss_inc    = 1'b1;
                    state_d     = MISS;
                end
            end
            MISS: state_d = (vtag_q[24] && vtag_q[23]) ? WRITEBACK : FILL;
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {vtag_q[22:0], idx_q, 5'b0};
                mem_data_o   = line_q;
                if (mem_ack_i) state_d = FILL;
            end
            FILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag_q, idx_q, 5'b0};
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_tag_o    = {2'b10, tag_q};
                sram_data_o   = line_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are forced quiet while reset is asserted, even with a CPU request present.
        if (!rst_i) begin
            cpu_data_o    = '0;
            cpu_stall_o   = 1'b0;
            sram_addr_o   = '0;
            sram_tag_o    = '0;
            sram_data_o   = '0;
            sram_enable_o = 1'b0;
            sram_write_o  = 1'b0;
            hit_inc       = 1'b0;
            miss_inc      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            idx_q      <= '0;
            vtag_q     <= '0;
            line_q     <= '0;
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            err_q      <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q <= state_d;
            if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (state_q == REFILL)
                refill_q <= 1'b1;
            else if (state_q == IDLE && req)
                refill_q <= 1'b0;
            if (miss_inc) begin
                tag_q  <= cpu_addr_i[31:9];
                idx_q  <= cpu_addr_i[8:5];
                vtag_q <= sram_tag_i;
                line_q <= sram_data_i;
            end
            // The victim line has been written back by now, so the fill reuses its register.
            if (state_q == FILL && mem_ack_i) line_q <= mem_data_i;
            if (state_d != state_q)
                wait_q <= '0;
            else if (waiting && wait_q != CW'(MEM_ACK_TIMEOUT))
                wait_q <= wait_q + 1'b1;
            if (waiting && !mem_ack_i && wait_q == CW'(MEM_ACK_TIMEOUT - 1))
                err_q <= 1'b1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign err_o      = err_q;

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Controller that sequences the 2-way, 16-set, 256-bit-line data-cache SRAM between the CPU memory stage and off-chip data memory.
- Performs hit/miss handling and write-allocate with write-back of dirty victims.
- Stalls the pipeline while a miss is serviced.
- Keeps hit/miss statistics counters for performance reporting.

Parameters:
- MEM_ACK_TIMEOUT, 255: cycles to wait for mem_ack_i before raising err_o. The request keeps being held after a timeout.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- cpu_addr_i  in  32  byte address: tag [31:9], index [8:5], word [4:2]
- cpu_data_i  in  32  store data
- cpu_read_i  in  1  load request
- cpu_write_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  pipeline stall
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_enable_o  out  1  SRAM access
- sram_write_o  out  1  SRAM line write
- sram_tag_i  in  25  hit-way tag on hit; LRU victim tag on miss
- sram_data_i  in  256  hit-way line on hit; victim line on miss
- sram_hit_i  in  1  lookup hit
- mem_addr_o  out  32  line address, [4:0]=0
- mem_data_o  out  256  write-back line
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1=write-back, 0=fill
- mem_data_i  in  256  fill line
- mem_ack_i  in  1  one-cycle completion pulse
- hit_cnt_o  out  32  first-access hits, wraps
- miss_cnt_o  out  32  misses, wraps
- err_o  out  1  sticky memory timeout flag

Behaviour:
- Reset (rst_i=0, async): state IDLE; all outputs 0; counters 0; err_o 0; refill flag 0; latched address/line registers 0.
- req = cpu_read_i | cpu_write_i. If both are high, the access is a write.
- sram_enable_o = req in IDLE; 1 in REFILL; 0 in all other states.
- sram_addr_o = cpu_addr_i[8:5] in IDLE, latched index otherwise.
- IDLE, req & sram_hit_i:
  - Read: cpu_data_o = sram_data_i word cpu_addr_i[4:2] (word w = bits [32w+31:32w]), combinational, zero latency, cpu_stall_o=0.
  - Write: same cycle, sram_write_o=1, sram_data_o = sram_data_i with the selected word replaced by cpu_data_i, sram_tag_o = {1,1,cpu tag}, cpu_stall_o=0.
  - hit_cnt_o += 1 unless refill flag is set. Refill flag clears on any IDLE cycle with req.
- IDLE, req & ~sram_hit_i:
  - cpu_stall_o=1 combinationally.
  - Latch cpu address, victim tag and victim line.
  - miss_cnt_o += 1; next state MISS.
- MISS (1 cycle): victim tag bits [24] and [23] both 1 -> WRITEBACK, else -> FILL.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {victim tag[22:0], index, 5'b0}; mem_data_o = latched victim line.
  - On mem_ack_i -> FILL; enable drops the following cycle.
- FILL:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {latched tag, index, 5'b0}.
  - On mem_ack_i, latch mem_data_i -> REFILL.
- REFILL (1 cycle):
  - sram_enable_o=1, sram_write_o=1, sram_tag_o={1,0,latched tag}, sram_data_o = latched fill line.
  - Set refill flag -> IDLE. The access is replayed in IDLE, hits, and completes (store merge happens there).
- cpu_stall_o = 1 in every state except IDLE; in IDLE it equals req & ~sram_hit_i.
- mem_ack_i outside WRITEBACK/FILL is ignored.
- Wait counter resets on entry to WRITEBACK/FILL. On reaching MEM_ACK_TIMEOUT, err_o=1 (sticky until reset); the state machine keeps waiting.
- Reset mid-miss: immediate return to IDLE, mem_enable_o drops asynchronously, no SRAM write.
- CPU must hold its request while stalled. Memory addressing uses latched values only.
- Counters wrap 0xFFFFFFFF -> 0.

Test Plan:
- Cold read of 0x0000_0400 -> MISS->FILL (mem_addr_o=0x400, mem_write_o=0) -> ack with line word0=0xDEADBEEF -> REFILL writes tag {1,0,23'h2} -> next cycle cpu_data_o=0xDEADBEEF, stall low; miss_cnt=1, hit_cnt=0.
- Store 0x12345678 to 0x404 after the fill above -> single-cycle hit, sram_write_o=1, word1 replaced, tag dirty bit=1, hit_cnt=1, no stall.
- Miss on set 0 with dirty victim tag 23'h2 -> WRITEBACK mem_addr_o=0x400, mem_write_o=1, mem_data_o=victim line, then FILL at new address; exactly two mem_enable_o phases.
- cpu_read_i and cpu_write_i both high on hit -> treated as store (sram_write_o=1).
- rst_i low during FILL with mem_enable_o=1 -> mem_enable_o, cpu_stall_o, counters 0 immediately; later ack pulse is ignored.
- MEM_ACK_TIMEOUT=4, no ack -> err_o rises after 4 FILL cycles; late ack completes the refill normally with err_o still 1.
